// File: rtl/fft_pkg.sv
// Shared FFT definitions: default frame geometry and the sample-loader state encoding.
package fft_pkg;

  localparam int FFT_WORDSIZE   = 16;
  localparam int FFT_NUMSAMPLES = 32;
  localparam int FFT_ADDRSIZE   = 3;
  localparam int FFT_LANES      = 4;

  typedef enum logic [2:0] {
    ST_FILL   = 3'd0,
    ST_FULL   = 3'd1,
    ST_ARM    = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } ld_state_e;

endpackage

// File: rtl/fft_sample_loader_bank.sv
// Four-lane sample buffer: one write port addressed by (lane,row), one full-row read port.
module sample_bank
  import fft_pkg::*;
#(
  parameter int WORDSIZE = FFT_WORDSIZE,
  parameter int ADDRSIZE = FFT_ADDRSIZE
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic [1:0]          wr_lane_i,
  input  logic [ADDRSIZE-1:0] wr_row_i,
  input  logic [WORDSIZE-1:0] wr_data_i,
  input  logic [ADDRSIZE-1:0] rd_row_i,
  output logic [WORDSIZE-1:0] rd_lane0_o,
  output logic [WORDSIZE-1:0] rd_lane1_o,
  output logic [WORDSIZE-1:0] rd_lane2_o,
  output logic [WORDSIZE-1:0] rd_lane3_o
);

  localparam int NROWS = 1 << ADDRSIZE;

  // No reset on the storage: every frame fully overwrites it before readout.
  logic [WORDSIZE-1:0] mem_q [NROWS][FFT_LANES];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_row_i][wr_lane_i] <= wr_data_i;
    end
  end

  assign rd_lane0_o = mem_q[rd_row_i][0];
  assign rd_lane1_o = mem_q[rd_row_i][1];
  assign rd_lane2_o = mem_q[rd_row_i][2];
  assign rd_lane3_o = mem_q[rd_row_i][3];

endmodule

// File: rtl/fft_sample_loader.sv
// Collects a serial frame into a 4-lane buffer, then streams it to the FFT one row per
// cycle under an ld_data / ld_done handshake once the system grants load_req.
module fft_sample_loader
  import fft_pkg::*;
#(
  parameter int WORDSIZE   = FFT_WORDSIZE,
  parameter int NUMSAMPLES = FFT_NUMSAMPLES,
  parameter int ADDRSIZE   = FFT_ADDRSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [WORDSIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                load_req,
  output logic                ld_data,
  output logic                ld_done,
  output logic [WORDSIZE-1:0] data_in0,
  output logic [WORDSIZE-1:0] data_in1,
  output logic [WORDSIZE-1:0] data_in2,
  output logic [WORDSIZE-1:0] data_in3,
  output logic                frame_full
);

  localparam int NROWS = NUMSAMPLES / 4;
  localparam int CW    = ADDRSIZE + 3;
  localparam logic [CW-1:0]       LAST_SAMPLE = CW'(NUMSAMPLES - 1);
  localparam logic [ADDRSIZE-1:0] LAST_ROW    = ADDRSIZE'(NROWS - 1);

  ld_state_e           state_q;
  logic [CW-1:0]       count_q;
  logic [ADDRSIZE-1:0] row_q;
  logic                ld_data_q;
  logic                ld_done_q;
  logic                frame_full_q;
  logic [WORDSIZE-1:0] data0_q, data1_q, data2_q, data3_q;

  logic                wr_en_s;
  logic [ADDRSIZE-1:0] rd_row_s;
  logic [WORDSIZE-1:0] rd0_s, rd1_s, rd2_s, rd3_s;

  assign s_ready = (state_q == ST_FILL);
  assign wr_en_s = s_ready & s_valid;

  // Output registers lag the read address by one: prefetch the row after the one on display.
  always_comb begin
    rd_row_s = '0;
    if (state_q == ST_STREAM) begin
      rd_row_s = row_q + ADDRSIZE'(1);
    end else begin
      rd_row_s = '0;
    end
  end

  sample_bank #(
    .WORDSIZE (WORDSIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_bank (
    .clk        (clk),
    .wr_en_i    (wr_en_s),
    .wr_lane_i  (count_q[1:0]),
    .wr_row_i   (count_q[ADDRSIZE+1:2]),
    .wr_data_i  (s_data),
    .rd_row_i   (rd_row_s),
    .rd_lane0_o (rd0_s),
    .rd_lane1_o (rd1_s),
    .rd_lane2_o (rd2_s),
    .rd_lane3_o (rd3_s)
  );

  // Frame sequencer: fill, wait for grant, one-cycle ld_data, stream rows, one-cycle ld_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FILL;
      count_q      <= '0;
      row_q        <= '0;
      ld_data_q    <= 1'b0;
      ld_done_q    <= 1'b0;
      frame_full_q <= 1'b0;
      data0_q      <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      data3_q      <= '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (s_valid) begin
            count_q <= count_q + CW'(1);
            if (count_q == LAST_SAMPLE) begin
              state_q      <= ST_FULL;
              frame_full_q <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (load_req) begin
            state_q      <= ST_ARM;
            ld_data_q    <= 1'b1;
            frame_full_q <= 1'b0;
          end
        end
        ST_ARM: begin
          ld_data_q <= 1'b0;
          row_q     <= '0;
          data0_q   <= rd0_s;
          data1_q   <= rd1_s;
          data2_q   <= rd2_s;
          data3_q   <= rd3_s;
          state_q   <= ST_STREAM;
        end
        ST_STREAM: begin
          if (row_q == LAST_ROW) begin
            state_q   <= ST_FIN;
            ld_done_q <= 1'b1;
            data0_q   <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            data3_q   <= '0;
          end else begin
            row_q   <= row_q + ADDRSIZE'(1);
            data0_q <= rd0_s;
            data1_q <= rd1_s;
            data2_q <= rd2_s;
            data3_q <= rd3_s;
          end
        end
        ST_FIN: begin
          ld_done_q <= 1'b0;
          count_q   <= '0;
          row_q     <= '0;
          state_q   <= ST_FILL;
        end
        default: begin
          state_q      <= ST_FILL;
          count_q      <= '0;
          row_q        <= '0;
          ld_data_q    <= 1'b0;
          ld_done_q    <= 1'b0;
          frame_full_q <= 1'b0;
          data0_q      <= '0;
          data1_q      <= '0;
          data2_q      <= '0;
          data3_q      <= '0;
        end
      endcase
    end
  end

  assign ld_data    = ld_data_q;
  assign ld_done    = ld_done_q;
  assign frame_full = frame_full_q;
  assign data_in0   = data0_q;
  assign data_in1   = data1_q;
  assign data_in2   = data2_q;
  assign data_in3   = data3_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Scoreboard bench for fft_sample_loader: stimulus queues expected transfers, a negedge
// monitor pops and checks them as ld_data / rows / ld_done appear.
module tb_fft_sample_loader;

  localparam int NS = 32;
  localparam int NR = NS / 4;
  localparam int K_ARM  = 0;
  localparam int K_ROW  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'd0;
  logic        s_ready;
  logic        load_req = 1'b0;
  logic        ld_data, ld_done, frame_full;
  logic [15:0] data_in0, data_in1, data_in2, data_in3;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   phase = 0;
  int   mrow = 0;

  always #5 clk = ~clk;

  fft_sample_loader dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .load_req   (load_req),
    .ld_data    (ld_data),
    .ld_done    (ld_done),
    .data_in0   (data_in0),
    .data_in1   (data_in1),
    .data_in2   (data_in2),
    .data_in3   (data_in3),
    .frame_full (frame_full)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] row_val(input int base, input int k);
    logic [15:0] a, b, c, d;
    a = 16'(base + 4 * k);
    b = 16'(base + 4 * k + 1);
    c = 16'(base + 4 * k + 2);
    d = 16'(base + 4 * k + 3);
    return {d, c, b, a};
  endfunction

  task automatic push_frame(input int base);
    exp_t e;
    e.kind = K_ARM;  e.data = 64'd0;  exp_q.push_back(e);
    for (int k = 0; k < NR; k++) begin
      e.kind = K_ROW; e.data = row_val(base, k); exp_q.push_back(e);
    end
    e.kind = K_DONE; e.data = 64'd0;  exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the last sample is accepted.
  task automatic send_frame(input int base, input bit rnd);
    int  n = 0;
    int  guard = 0;
    bit  hs;
    while (n < NS && guard < 2000) begin
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = 16'(base + n);
      hs      = s_valid && s_ready;
      @(posedge clk); #1;
      if (hs) n++;
      guard++;
    end
    s_valid = 1'b0;
    check("frame_accept_count", 64'(n), 64'(NS));
    push_frame(base);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || phase != 0) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", 64'(cyc < 200), 64'd1);
  endtask

  // Monitor: pops one expected item per transfer cycle and polices idle cycles.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0;
        mrow  = 0;
      end else begin
        if (ld_data && ld_done) check("ld_overlap", 64'd1, 64'd0);
        if (ld_data) begin
          if (phase != 0 || exp_q.size() == 0) begin
            check("unexpected_ld_data", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("arm_kind", 64'(e.kind), 64'(K_ARM));
            check("arm_data", {data_in3, data_in2, data_in1, data_in0}, e.data);
            phase = 1;
            mrow  = 0;
          end
        end else if (phase == 1) begin
          if (exp_q.size() == 0) begin
            check("row_queue_empty", 64'd1, 64'd0);
            phase = 0;
          end else begin
            e = exp_q.pop_front();
            check("row_kind", 64'(e.kind), 64'(K_ROW));
            check($sformatf("row%0d_data", mrow), {data_in3, data_in2, data_in1, data_in0}, e.data);
            check("row_no_done", 64'(ld_done), 64'd0);
            mrow++;
            if (mrow == NR) phase = 2;
          end
        end else if (phase == 2) begin
          check("ld_done_pulse", 64'(ld_done), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("done_kind", 64'(e.kind), 64'(K_DONE));
            check("done_data", {data_in3, data_in2, data_in1, data_in0}, e.data);
          end
          phase = 0;
        end else begin
          check("idle_ld_done", 64'(ld_done), 64'd0);
          check("idle_data", {data_in3, data_in2, data_in1, data_in0}, 64'd0);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_ld_data", 64'(ld_data), 64'd0);
    check("rst_ld_done", 64'(ld_done), 64'd0);
    check("rst_frame_full", 64'(frame_full), 64'd0);
    check("rst_data", {data_in3, data_in2, data_in1, data_in0}, 64'd0);

    // Contiguous frame of i, then 20 cycles of no grant with stray s_valid
    send_frame(0, 1'b0);
    check("s_ready_drop", 64'(s_ready), 64'd0);
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    for (int c = 0; c < 20; c++) begin
      check("wait_frame_full", 64'(frame_full), 64'd1);
      check("wait_no_ld_data", 64'(ld_data), 64'd0);
      check("wait_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
    end
    s_valid  = 1'b0;
    load_req = 1'b1;
    @(posedge clk); #1;
    check("ld_data_after_req", 64'(ld_data), 64'd1);
    check("frame_full_cleared", 64'(frame_full), 64'd0);
    load_req = 1'b0;
    wait_drain();
    check("s_ready_after_fin", 64'(s_ready), 64'd1);

    // Randomly gapped s_valid
    send_frame(200, 1'b1);
    check("s_ready_drop_rnd", 64'(s_ready), 64'd0);
    s_valid  = 1'b1;
    s_data   = 16'hDEAD;
    load_req = 1'b1;
    @(posedge clk); #1;
    s_valid  = 1'b0;
    load_req = 1'b0;
    wait_drain();

    // Reset during row 3 of the stream
    send_frame(50, 1'b0);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_row3", 64'(data_in0), 64'(50 + 12));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_s_ready", 64'(s_ready), 64'd1);
    check("abort_ld_done", 64'(ld_done), 64'd0);
    check("abort_data", {data_in3, data_in2, data_in1, data_in0}, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    send_frame(100, 1'b0);
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    wait_drain();

    // Back-to-back frames with load_req tied high
    load_req = 1'b1;
    send_frame(300, 1'b0);
    send_frame(400, 1'b0);
    wait_drain();
    load_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_s_ready", 64'(s_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
